// File: rtl/io_pkg.sv
// Shared I/O package: register control codes and the default
// data width used by both the input port and the output register.
package io_pkg;

  localparam int IO_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_INCR = 2'd1,
    CTRL_LOAD = 2'd2,
    CTRL_CLR  = 2'd3
  } io_ctrl_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head output.
// A pop on a full FIFO frees the slot for a same-edge push.
module sync_fifo
  import io_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset, empty masks them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and count update
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_input_port.sv
// CPU input port: synchronises an external strobe/data pair,
// queues bytes in a FIFO and flags bytes dropped while full.
module io_input_port
  import io_pkg::*;
#(
  parameter int DATA_WIDTH  = IO_DATA_WIDTH,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [DATA_WIDTH-1:0] ext_data,
  input  logic                  ext_strobe,
  output logic                  ext_full,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  input  logic                  cpu_read,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] strb_q;
  logic [DATA_WIDTH-1:0]  data_q [SYNC_STAGES];
  logic                   s_prev_q;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   s_sync;
  logic                   push_req;
  logic                   drop;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign s_sync   = strb_q[SYNC_STAGES-1];
  assign push_req = s_sync & ~s_prev_q;
  assign drop     = push_req & fifo_full & ~cpu_read;
  assign ext_full = (fifo_count == CW'(DEPTH));
  assign cpu_valid = ~fifo_empty;
  assign overflow = ovf_q;

  // Sticky overflow: a drop beats a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clear) begin
      ovf_d = 1'b0;
    end
  end

  // Strobe/data synchroniser, edge flop and overflow flag
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      strb_q   <= '0;
      s_prev_q <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      strb_q    <= {strb_q[SYNC_STAGES-2:0], ext_strobe};
      s_prev_q  <= s_sync;
      ovf_q     <= ovf_d;
      data_q[0] <= ext_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push_req),
    .pop        (cpu_read),
    .din        (data_q[SYNC_STAGES-1]),
    .dout       (cpu_data),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port: latency, full/overflow,
// simultaneous push+pop, empty reads, reset flush, flag priority.
module tb_io_input_port;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] ext_data;
  logic       ext_strobe;
  logic       ext_full;
  logic [7:0] cpu_data;
  logic       cpu_valid;
  logic       cpu_read;
  logic       overflow;
  logic       overflow_clear;

  int total = 0;
  int bad   = 0;

  io_input_port dut (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .ext_data       (ext_data),
    .ext_strobe     (ext_strobe),
    .ext_full       (ext_full),
    .cpu_data       (cpu_data),
    .cpu_valid      (cpu_valid),
    .cpu_read       (cpu_read),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe rise before edge k, push lands at edge k+2;
  // rd/clr are applied at that push edge.
  task automatic push_byte(input logic [7:0] b, input logic rd,
                           input logic clr);
    ext_data   = b;
    ext_strobe = 1'b1;
    step();
    step();
    cpu_read       = rd;
    overflow_clear = clr;
    step();
    cpu_read       = 1'b0;
    overflow_clear = 1'b0;
    ext_strobe     = 1'b0;
    step();
    step();
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(cpu_valid), 32'h1);
    chk({tag, "_data"}, 32'(cpu_data), 32'(exp));
    cpu_read = 1'b1;
    step();
    cpu_read = 1'b0;
  endtask

  initial begin
    sync_reset     = 1'b1;
    ext_data       = 8'h00;
    ext_strobe     = 1'b0;
    cpu_read       = 1'b0;
    overflow_clear = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(cpu_valid), 32'h0);
    chk("rst_data", 32'(cpu_data), 32'h0);
    chk("rst_full", 32'(ext_full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // 1: latency
    sync_reset = 1'b0;
    ext_data   = 8'hA5;
    ext_strobe = 1'b1;
    step();
    chk("lat_e1", 32'(cpu_valid), 32'h0);
    step();
    chk("lat_e2", 32'(cpu_valid), 32'h0);
    step();
    chk("lat_e3", 32'(cpu_valid), 32'h1);
    chk("lat_data", 32'(cpu_data), 32'hA5);
    ext_strobe = 1'b0;
    step();
    step();
    read_byte("lat_rd", 8'hA5);
    chk("lat_empty", 32'(cpu_valid), 32'h0);

    // 2: fill, overflow drop
    push_byte(8'h11, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b0);
    chk("fill3_full", 32'(ext_full), 32'h0);
    push_byte(8'h44, 1'b0, 1'b0);
    chk("fill4_full", 32'(ext_full), 32'h1);
    chk("fill4_ovf", 32'(overflow), 32'h0);
    push_byte(8'h55, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'h1);
    chk("drop_full", 32'(ext_full), 32'h1);
    read_byte("ovf_rd0", 8'h11);
    read_byte("ovf_rd1", 8'h22);
    read_byte("ovf_rd2", 8'h33);
    read_byte("ovf_rd3", 8'h44);
    chk("ovf_empty", 32'(cpu_valid), 32'h0);
    chk("ovf_empty_data", 32'(cpu_data), 32'h0);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'h0);

    // 3: push+pop while full
    push_byte(8'h11, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b0);
    push_byte(8'h44, 1'b0, 1'b0);
    push_byte(8'h55, 1'b1, 1'b0);
    chk("pp_ovf", 32'(overflow), 32'h0);
    chk("pp_full", 32'(ext_full), 32'h1);
    read_byte("pp_rd0", 8'h22);
    read_byte("pp_rd1", 8'h33);
    read_byte("pp_rd2", 8'h44);
    read_byte("pp_rd3", 8'h55);
    chk("pp_empty", 32'(cpu_valid), 32'h0);

    // 4: reads on empty are ignored
    for (int i = 0; i < 3; i++) begin
      cpu_read = 1'b1;
      step();
      cpu_read = 1'b0;
      step();
      chk("und_valid", 32'(cpu_valid), 32'h0);
      chk("und_data", 32'(cpu_data), 32'h0);
    end
    push_byte(8'h7E, 1'b0, 1'b0);
    read_byte("und_rd", 8'h7E);
    chk("und_empty", 32'(cpu_valid), 32'h0);

    // 6: drop beats clear, then clear alone
    push_byte(8'hC1, 1'b0, 1'b0);
    push_byte(8'hC2, 1'b0, 1'b0);
    push_byte(8'hC3, 1'b0, 1'b0);
    push_byte(8'hC4, 1'b0, 1'b0);
    push_byte(8'h99, 1'b0, 1'b0);
    chk("pri_set", 32'(overflow), 32'h1);
    push_byte(8'h9A, 1'b0, 1'b1);
    chk("pri_hold", 32'(overflow), 32'h1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    chk("pri_clr", 32'(overflow), 32'h0);
    read_byte("pri_rd0", 8'hC1);
    read_byte("pri_rd1", 8'hC2);
    read_byte("pri_rd2", 8'hC3);
    read_byte("pri_rd3", 8'hC4);

    // 5: reset flushes FIFO and in-flight strobe
    push_byte(8'hAA, 1'b0, 1'b0);
    push_byte(8'hBB, 1'b0, 1'b0);
    push_byte(8'hCC, 1'b0, 1'b0);
    chk("mr_pre", 32'(cpu_data), 32'hAA);
    ext_data   = 8'hDD;
    ext_strobe = 1'b1;
    step();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    ext_strobe = 1'b0;
    chk("mr_rst_valid", 32'(cpu_valid), 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("mr_valid", 32'(cpu_valid), 32'h0);
    chk("mr_data", 32'(cpu_data), 32'h0);
    chk("mr_ovf", 32'(overflow), 32'h0);
    chk("mr_full", 32'(ext_full), 32'h0);
    push_byte(8'hEE, 1'b0, 1'b0);
    read_byte("mr_rd", 8'hEE);
    chk("mr_end", 32'(cpu_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
